// File: rtl/bus_xfer_pkg.sv
// Shared types and defaults for the byte-wide bus transfer driver and its sampler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_xfer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } bus_xfer_state_e;

  // One observed transfer: last data byte, address byte, number of data bytes.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_CNT_W-1:0]  count;
  } transfer_s;

endpackage

// File: rtl/bus_xfer_driver.sv
// Drives one request as an address byte then up to MAX_LEN data bytes on bus_data, ending with a stop_cond pulse.
// Latency: address on bus the cycle after accept; each data byte the cycle after its accept; stop one cycle after the last byte.
// Backpressure: source stalls show as bus_valid=0 with bus_data held; req_ready only in IDLE, data_ready while bytes remain and no abort.
//
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   req_valid/req_ready          - request handshake, with req_addr and req_len (0 = address only, clamped to MAX_LEN)
//   data_valid/data_ready        - source byte handshake, with data_byte
//   abort                        - ends the current transfer early (ignored in IDLE and STOP)
//   bus_data, bus_valid          - registered bus byte and its new-byte strobe
//   stop_cond                    - one-cycle end-of-transfer pulse
//   busy, last_aborted, xfer_count - status: not idle, last end was an abort, transfers ended (wraps)
module bus_xfer_driver
  import bus_xfer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_byte,
  input  logic              abort,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              stop_cond,
  output logic              busy,
  output logic              last_aborted,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  bus_xfer_state_e   state_q, state_d;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  len_clamped;
  logic [DATA_W-1:0] bus_data_q;
  logic              bus_valid_q;
  logic              stop_q;
  logic              last_aborted_q;
  logic [CNT_W-1:0]  xfer_count_q;

  // Per-cycle strobes from the FSM that steer the datapath registers.
  logic accept_req;
  logic take_byte;
  logic enter_stop;
  logic abort_stop;

  assign len_clamped = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    accept_req = 1'b0;
    take_byte  = 1'b0;
    enter_stop = 1'b0;
    abort_stop = 1'b0;
    case (state_q)
      IDLE: begin
        // abort has no meaning here, so a request alongside it is still taken.
        req_ready = 1'b1;
        if (req_valid) begin
          accept_req = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR, DATA: begin
        data_ready = (remaining_q != '0) && !abort;
        // abort outranks both completion and a byte offered in the same cycle.
        if (abort) begin
          abort_stop = 1'b1;
          enter_stop = 1'b1;
          state_d    = STOP;
        end else if (remaining_q == '0) begin
          enter_stop = 1'b1;
          state_d    = STOP;
        end else if (data_valid) begin
          take_byte = 1'b1;
          state_d   = DATA;
        end
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q    <= '0;
      bus_data_q     <= '0;
      bus_valid_q    <= 1'b0;
      stop_q         <= 1'b0;
      last_aborted_q <= 1'b0;
      xfer_count_q   <= '0;
    end else begin
      bus_valid_q <= accept_req | take_byte;
      stop_q      <= enter_stop;
      // bus_data only changes when a new byte goes out, so stalls hold the last value.
      if (accept_req) begin
        bus_data_q  <= req_addr;
        remaining_q <= len_clamped;
      end else if (take_byte) begin
        bus_data_q  <= data_byte;
        remaining_q <= remaining_q - LEN_W'(1);
      end else if (abort_stop) begin
        remaining_q <= '0;
      end
      if (enter_stop) begin
        xfer_count_q   <= xfer_count_q + CNT_W'(1);
        last_aborted_q <= abort_stop;
      end
    end
  end

  assign bus_data     = bus_data_q;
  assign bus_valid    = bus_valid_q;
  assign stop_cond    = stop_q;
  assign busy         = (state_q != IDLE);
  assign last_aborted = last_aborted_q;
  assign xfer_count   = xfer_count_q;

endmodule

// File: tb/tb_bus_xfer_driver.sv
module tb_bus_xfer_driver;
  import bus_xfer_pkg::*;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_byte;
  logic              abort;
  logic [DATA_W-1:0] bus_data;
  logic              bus_valid;
  logic              stop_cond;
  logic              busy;
  logic              last_aborted;
  logic [CNT_W-1:0]  xfer_count;

  int n_checks;
  int n_err;

  transfer_s cur;
  transfer_s snap;
  logic      seen_addr;

  bus_xfer_driver #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_byte   (data_byte),
    .abort       (abort),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .stop_cond   (stop_cond),
    .busy        (busy),
    .last_aborted(last_aborted),
    .xfer_count  (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sampler: first valid byte of a transfer is the address, the rest are data.
  always @(negedge clk) begin
    if (rst) begin
      cur       <= '0;
      seen_addr <= 1'b0;
    end else begin
      if (bus_valid) begin
        if (!seen_addr) begin
          cur.addr  <= bus_data;
          seen_addr <= 1'b1;
        end else begin
          cur.data  <= bus_data;
          cur.count <= cur.count + 32'd1;
        end
      end
      if (stop_cond) begin
        snap      <= cur;
        cur       <= '0;
        seen_addr <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(v));
    chk({tag, ".bus_data"},  32'(bus_data),  32'(d));
    chk({tag, ".stop_cond"}, 32'(stop_cond), 32'(s));
  endtask

  task automatic quiet();
    req_valid  = 1'b0;
    data_valid = 1'b0;
    abort      = 1'b0;
  endtask

  // Present a request in the current (IDLE) cycle and advance past the accept edge.
  task automatic issue(input logic [7:0] a, input logic [4:0] n, input string tag);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst        = 1'b1;
    req_addr   = '0;
    req_len    = '0;
    data_byte  = '0;
    quiet();
    tick();
    tick();

    // Reset state
    chk_bus("rst", 1'b0, 8'h00, 1'b0);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.count", xfer_count, 32'd0);
    chk("rst.last_aborted", 32'(last_aborted), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle.req_ready", 32'(req_ready), 32'd1);

    // T1: addr 00, len 1, byte AA offered at once
    issue(8'h00, 5'd1, "t1");
    data_valid = 1'b1; data_byte = 8'hAA; #1;
    chk_bus("t1.addr", 1'b1, 8'h00, 1'b0);
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.data_ready", 32'(data_ready), 32'd1);
    tick();
    data_valid = 1'b0; #1;
    chk_bus("t1.d0", 1'b1, 8'hAA, 1'b0);
    chk("t1.data_ready_done", 32'(data_ready), 32'd0);
    tick();
    chk_bus("t1.stop", 1'b0, 8'hAA, 1'b1);
    chk("t1.count", xfer_count, 32'd1);
    chk("t1.req_ready_stop", 32'(req_ready), 32'd0);
    tick();
    chk("t1.stop_one_cycle", 32'(stop_cond), 32'd0);
    chk("t1.busy_after", 32'(busy), 32'd0);
    chk("t1.snap_addr",  32'(snap.addr), 32'h00);
    chk("t1.snap_data",  32'(snap.data), 32'hAA);
    chk("t1.snap_count", snap.count, 32'd1);

    // T2: addr 3C, len 3, two-cycle gap before 22
    issue(8'h3C, 5'd3, "t2");
    data_valid = 1'b1; data_byte = 8'h11; #1;
    chk_bus("t2.c1", 1'b1, 8'h3C, 1'b0);
    tick();
    data_valid = 1'b0; #1;
    chk_bus("t2.c2", 1'b1, 8'h11, 1'b0);
    tick();
    chk_bus("t2.c3", 1'b0, 8'h11, 1'b0);
    tick();
    data_valid = 1'b1; data_byte = 8'h22; #1;
    chk_bus("t2.c4", 1'b0, 8'h11, 1'b0);
    tick();
    data_byte = 8'h33; #1;
    chk_bus("t2.c5", 1'b1, 8'h22, 1'b0);
    tick();
    data_valid = 1'b0; #1;
    chk_bus("t2.c6", 1'b1, 8'h33, 1'b0);
    tick();
    chk_bus("t2.c7", 1'b0, 8'h33, 1'b1);
    chk("t2.count", xfer_count, 32'd2);
    tick();

    // T3: len 0, address only; an offered byte must not be taken
    issue(8'h5A, 5'd0, "t3");
    data_valid = 1'b1; data_byte = 8'h77; #1;
    chk_bus("t3.addr", 1'b1, 8'h5A, 1'b0);
    chk("t3.data_ready", 32'(data_ready), 32'd0);
    tick();
    data_valid = 1'b0; #1;
    chk_bus("t3.stop", 1'b0, 8'h5A, 1'b1);
    chk("t3.count", xfer_count, 32'd3);
    tick();

    // T4: len 4, abort while the 2nd byte is offered
    issue(8'h40, 5'd4, "t4");
    data_valid = 1'b1; data_byte = 8'h01; #1;
    chk_bus("t4.addr", 1'b1, 8'h40, 1'b0);
    tick();
    data_byte = 8'h02; abort = 1'b1; #1;
    chk_bus("t4.d0", 1'b1, 8'h01, 1'b0);
    chk("t4.data_ready_abort", 32'(data_ready), 32'd0);
    tick();
    quiet(); #1;
    chk_bus("t4.stop", 1'b0, 8'h01, 1'b1);
    chk("t4.last_aborted", 32'(last_aborted), 32'd1);
    chk("t4.count", xfer_count, 32'd4);
    tick();
    chk("t4.idle", 32'(busy), 32'd0);

    // T4b: abort alongside a request in IDLE is ignored; normal end clears last_aborted
    abort = 1'b1;
    issue(8'h99, 5'd0, "t4b");
    abort = 1'b0; #1;
    chk_bus("t4b.addr", 1'b1, 8'h99, 1'b0);
    chk("t4b.busy", 32'(busy), 32'd1);
    tick();
    chk_bus("t4b.stop", 1'b0, 8'h99, 1'b1);
    chk("t4b.last_aborted", 32'(last_aborted), 32'd0);
    chk("t4b.count", xfer_count, 32'd5);
    tick();

    // T5: reset mid-DATA, then a clean transfer
    issue(8'h21, 5'd3, "t5");
    data_valid = 1'b1; data_byte = 8'hA1; #1;
    tick();
    data_byte = 8'hA2; #1;
    chk_bus("t5.d0", 1'b1, 8'hA1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; data_valid = 1'b0; #1;
    chk_bus("t5.rst", 1'b0, 8'h00, 1'b0);
    chk("t5.busy",  32'(busy), 32'd0);
    chk("t5.count", xfer_count, 32'd0);
    tick();
    chk("t5.no_stop", 32'(stop_cond), 32'd0);
    issue(8'h22, 5'd1, "t5n");
    data_valid = 1'b1; data_byte = 8'hB1; #1;
    chk_bus("t5n.addr", 1'b1, 8'h22, 1'b0);
    tick();
    data_valid = 1'b0; #1;
    chk_bus("t5n.d0", 1'b1, 8'hB1, 1'b0);
    tick();
    chk_bus("t5n.stop", 1'b0, 8'hB1, 1'b1);
    chk("t5n.count", xfer_count, 32'd1);
    tick();

    // T6: req_len 31 clamps to 16 bytes
    issue(8'h66, 5'd31, "t6");
    for (int k = 0; k <= 16; k++) begin
      data_valid = 1'b1;
      data_byte  = 8'(8'h80 + k);
      #1;
      if (k == 0) chk_bus("t6.addr", 1'b1, 8'h66, 1'b0);
      else        chk_bus("t6.d", 1'b1, 8'(8'h80 + k - 1), 1'b0);
      chk("t6.data_ready", 32'(data_ready), (k < 16) ? 32'd1 : 32'd0);
      tick();
    end
    data_valid = 1'b0; #1;
    chk_bus("t6.stop", 1'b0, 8'h8F, 1'b1);
    chk("t6.count", xfer_count, 32'd2);
    tick();
    chk("t6.snap_count", snap.count, 32'd16);
    chk("t6.snap_data",  32'(snap.data), 32'h8F);
    chk("t6.snap_addr",  32'(snap.addr), 32'h66);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
